// File: rtl/ahb_wrr_scheduler.sv
// ---------------------------------------------------------------------------
// ahb_wrr_scheduler
//
// Weighted round-robin arbitration for one shared AHB slave port.
// MASTER_NUM masters compete for ownership. Ownership is held until the
// owner's last beat is accepted or the owner drops its request.
//
// Bandwidth share comes from per-master credit counters. Each counter is
// reloaded from the static weights once every requester has run out of credit.
// Every master also has a wait counter. Once a requester's wait counter reaches
// STARVE_LIMIT, that master is promoted ahead of the credit scheme.
//
// Ports
//   hclk     : clock, rising edge
//   hreset   : asynchronous, active-high reset
//   hreq     : per-master request
//   hlast    : per-master last beat of the current burst (used for the owner only)
//   hwait    : slave stall; while high no beat is accepted and ownership is frozen
//   hweight  : static weights, master i at [i*WEIGHT_BIT +: WEIGHT_BIT]; 0 acts as 1
//   hgrant   : registered one-hot grant, all-zero when idle
//   hsel     : |hgrant
//   hmaster  : index of the current owner (keeps the last owner when idle)
//   hstarve  : high in the first cycle of a grant issued by starvation promotion
// ---------------------------------------------------------------------------
module ahb_wrr_scheduler #(
    parameter int MASTER_NUM   = 4,
    parameter int WEIGHT_BIT   = 4,
    parameter int STARVE_LIMIT = 16,
    localparam int IDX_W       = $clog2(MASTER_NUM),
    localparam int WAIT_W      = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                             hclk,
    input  logic                             hreset,
    input  logic [MASTER_NUM-1:0]            hreq,
    input  logic [MASTER_NUM-1:0]            hlast,
    input  logic                             hwait,
    input  logic [MASTER_NUM*WEIGHT_BIT-1:0] hweight,
    output logic [MASTER_NUM-1:0]            hgrant,
    output logic                             hsel,
    output logic [IDX_W-1:0]                 hmaster,
    output logic                             hstarve
);

    localparam logic [WAIT_W-1:0] STARVE_SAT = WAIT_W'(STARVE_LIMIT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        owner_reg, owner_next;
    logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [MASTER_NUM-1:0]   hgrant_reg, hgrant_next;
    logic                    hstarve_reg, hstarve_next;

    logic [WEIGHT_BIT-1:0]   credit_reg  [MASTER_NUM];
    logic [WEIGHT_BIT-1:0]   credit_dec  [MASTER_NUM];
    logic [WEIGHT_BIT-1:0]   credit_next [MASTER_NUM];
    logic [WEIGHT_BIT-1:0]   reload_val  [MASTER_NUM];
    logic [WAIT_W-1:0]       wait_reg    [MASTER_NUM];
    logic [WAIT_W-1:0]       wait_next   [MASTER_NUM];

    logic [MASTER_NUM-1:0]   is_owner;
    logic [MASTER_NUM-1:0]   has_credit;
    logic [MASTER_NUM-1:0]   starving;

    logic                    busy;
    logic                    accept;
    logic                    release_evt;
    logic                    arb_en;
    logic [IDX_W-1:0]        search_base;

    logic                    starve_hit, rr_hit, req_hit;
    logic [IDX_W-1:0]        starve_idx, rr_idx, req_idx;
    int                      rot_pos;
    logic [IDX_W-1:0]        rot_idx;

    logic                    win_valid;
    logic                    win_starve;
    logic                    do_reload;
    logic [IDX_W-1:0]        win_idx;

    // ---------------------------------------------------------------------
    // Release detection. hwait high freezes everything except the wait counters.
    // ---------------------------------------------------------------------
    assign busy        = (state_reg == S_BUSY);
    assign accept      = busy & ~hwait & hlast[owner_reg];
    assign release_evt = busy & ~hwait & (hlast[owner_reg] | ~hreq[owner_reg]);
    assign arb_en      = ~busy | release_evt;

    // On a release the pointer moves to the old owner in this same cycle.
    // The search therefore starts just after that owner, which puts the
    // owner last in the search order.
    assign search_base = release_evt ? owner_reg : rr_ptr_reg;

    // ---------------------------------------------------------------------
    // Per-master credit, starvation and wait-counter logic
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_master
            assign is_owner[gi]   = busy && (owner_reg == IDX_W'(gi));
            assign reload_val[gi] = (hweight[gi*WEIGHT_BIT +: WEIGHT_BIT] == '0)
                                  ? WEIGHT_BIT'(1)
                                  : hweight[gi*WEIGHT_BIT +: WEIGHT_BIT];
            // The accepted beat is charged before arbitration. An owner that
            // has just spent its last credit then counts as out of credit in
            // this same cycle.
            assign credit_dec[gi] = (accept && is_owner[gi] && credit_reg[gi] != '0)
                                  ? credit_reg[gi] - WEIGHT_BIT'(1)
                                  : credit_reg[gi];
            assign has_credit[gi] = (credit_dec[gi] != '0);
            assign starving[gi]   = hreq[gi] && (wait_reg[gi] >= STARVE_SAT)
                                  && !(release_evt && is_owner[gi]);
            assign credit_next[gi] = do_reload ? reload_val[gi] : credit_dec[gi];

            always_comb begin
                wait_next[gi] = wait_reg[gi];
                if (!hreq[gi]) begin
                    wait_next[gi] = '0;
                end else if (win_valid && win_idx == IDX_W'(gi)) begin
                    wait_next[gi] = '0;
                end else if (is_owner[gi]) begin
                    wait_next[gi] = wait_reg[gi];
                end else if (wait_reg[gi] != STARVE_SAT) begin
                    wait_next[gi] = wait_reg[gi] + WAIT_W'(1);
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Winner search
    //   starvation : the lowest-index starving requester wins
    //   rotation   : the first requester after search_base; we record both
    //                the first one with credit and the first one at all. The
    //                second is the winner when a reload is needed, because
    //                after a reload every master has credit.
    // ---------------------------------------------------------------------
    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        rr_hit     = 1'b0;
        rr_idx     = '0;
        req_hit    = 1'b0;
        req_idx    = '0;
        rot_pos    = 0;
        rot_idx    = '0;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (starving[i]) begin
                starve_hit = 1'b1;
                starve_idx = IDX_W'(i);
            end
        end
        // Walk from the farthest position down to the nearest, so that the
        // last assignment made is the one closest to the pointer.
        for (int k = MASTER_NUM; k >= 1; k--) begin
            rot_pos = (int'(search_base) + k) % MASTER_NUM;
            rot_idx = IDX_W'(rot_pos);
            if (hreq[rot_idx]) begin
                req_hit = 1'b1;
                req_idx = rot_idx;
                if (has_credit[rot_idx]) begin
                    rr_hit = 1'b1;
                    rr_idx = rot_idx;
                end
            end
        end
    end

    always_comb begin
        win_valid  = 1'b0;
        win_starve = 1'b0;
        win_idx    = '0;
        do_reload  = 1'b0;
        if (arb_en) begin
            if (starve_hit) begin
                win_valid  = 1'b1;
                win_starve = 1'b1;
                win_idx    = starve_idx;
            end else if (rr_hit) begin
                win_valid  = 1'b1;
                win_idx    = rr_idx;
            end else if (req_hit) begin
                win_valid  = 1'b1;
                win_idx    = req_idx;
                do_reload  = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and registered outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        rr_ptr_next  = rr_ptr_reg;
        hgrant_next  = hgrant_reg;
        hstarve_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                hgrant_next = '0;
                if (win_valid) begin
                    state_next           = S_BUSY;
                    owner_next           = win_idx;
                    hgrant_next[win_idx] = 1'b1;
                    hstarve_next         = win_starve;
                end
            end
            S_BUSY: begin
                if (release_evt) begin
                    rr_ptr_next = owner_reg;
                    hgrant_next = '0;
                    if (win_valid) begin
                        owner_next           = win_idx;
                        hgrant_next[win_idx] = 1'b1;
                        hstarve_next         = win_starve;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next  = S_IDLE;
                hgrant_next = '0;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg   <= S_IDLE;
            owner_reg   <= '0;
            rr_ptr_reg  <= IDX_W'(MASTER_NUM - 1);
            hgrant_reg  <= '0;
            hstarve_reg <= 1'b0;
            for (int i = 0; i < MASTER_NUM; i++) begin
                credit_reg[i] <= '0;
                wait_reg[i]   <= '0;
            end
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            rr_ptr_reg  <= rr_ptr_next;
            hgrant_reg  <= hgrant_next;
            hstarve_reg <= hstarve_next;
            for (int i = 0; i < MASTER_NUM; i++) begin
                credit_reg[i] <= credit_next[i];
                wait_reg[i]   <= wait_next[i];
            end
        end
    end

    assign hgrant  = hgrant_reg;
    assign hsel    = |hgrant_reg;
    assign hmaster = owner_reg;
    assign hstarve = hstarve_reg;

endmodule
